wb_stage_ext: RTL and testbench

- Parametrised write-back stage with a valid/ready handshake, for the 5-stage ARM pipeline.
- Registers each instruction leaving Memory and selects the write-back source: ALU result, load data, or link address.
- Extends sub-word loads to full width and stalls for late memory data.
- Drives the register-file write port, and counts retired instructions.

---
 rtl/wb_stage_ext.sv | 187 ++++++++++++++++++
 tb/tb_wb_stage_ext.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_ext.sv
// wb_stage_ext: write-back stage for the 5-stage ARM pipeline.
// Registers each instruction leaving Memory, selects ALU / load / link result,
// extends sub-word loads, waits for late load data and counts retirements.
module wb_stage_ext #(
   parameter int unsigned WORD  = 32,
   parameter int unsigned RADDR = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic             iw_clk,
   input  logic             iw_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   input  logic [WORD-1:0]  pc_in,
   input  logic [WORD-1:0]  alu_result,
   input  logic [WORD-1:0]  read_data,
   input  logic             mem_ready,
   input  logic [1:0]       wb_sel,
   input  logic [1:0]       ld_size,
   input  logic             ld_signed,
   input  logic             reg_write_in,
   input  logic [RADDR-1:0] rd_in,
   output logic [WORD-1:0]  pc_out,
   output logic [WORD-1:0]  write_data,
   output logic [RADDR-1:0] rd_out,
   output logic             reg_write_out,
   output logic             wb_valid,
   output logic [CNT_W-1:0] retired_count
);

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      WAIT_MEM = 2'd1,
      COMMIT   = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Instruction context held while waiting for late load data.
   // Only the fields a pending load can still need are kept.
   logic [WORD-1:0]  pc_q;
   logic [1:0]       off_q;
   logic [1:0]       size_q;
   logic             signed_q;
   logic             regw_q;
   logic [RADDR-1:0] rd_q;

   logic             accept;
   logic             go_wait;
   logic             acc_commit;
   logic             mem_done;
   logic [WORD-1:0]  res;

   // Pick the addressed byte/half/word of the load data and extend to WORD.
   function automatic logic [WORD-1:0] ld_extend(
      input logic [WORD-1:0] d,
      input logic [1:0]      off,
      input logic [1:0]      sz,
      input logic            sgn
   );
      logic [7:0]      b;
      logic [15:0]     h;
      logic [WORD-1:0] r;
      case (off)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      case (sz)
         2'b01: begin
            r       = {WORD{sgn & h[15]}};
            r[15:0] = h;
         end
         2'b10: begin
            r      = {WORD{sgn & b[7]}};
            r[7:0] = b;
         end
         default: begin
            r       = {WORD{sgn & d[31]}};
            r[31:0] = d[31:0];
         end
      endcase
      return r;
   endfunction

   // Handshake qualifiers; flush overrides both accept and late data.
   always_comb begin
      accept     = in_valid & in_ready & ~flush;
      go_wait    = accept & (wb_sel == 2'b01) & ~mem_ready;
      acc_commit = accept & ~go_wait;
      mem_done   = (state == WAIT_MEM) & mem_ready & ~flush;
   end

   // Result for the commit being scheduled: current inputs on a direct
   // accept, held context plus late read_data when leaving WAIT_MEM.
   always_comb begin
      res = '0;
      if (acc_commit) begin
         case (wb_sel)
            2'b01:   res = ld_extend(read_data, alu_result[1:0], ld_size, ld_signed);
            2'b10:   res = pc_in + WORD'(4);
            default: res = alu_result;
         endcase
      end else begin
         res = ld_extend(read_data, off_q, size_q, signed_q);
      end
   end

   // State register.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) state <= EMPTY;
      else           state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_MEM: begin
            if (flush)          state_nxt = EMPTY;
            else if (mem_ready) state_nxt = COMMIT;
            else                state_nxt = WAIT_MEM;
         end
         default: begin
            if (go_wait)         state_nxt = WAIT_MEM;
            else if (acc_commit) state_nxt = COMMIT;
            else                 state_nxt = EMPTY;
         end
      endcase
   end

   // Output logic: only in_ready is combinational.
   always_comb begin
      in_ready = (state != WAIT_MEM);
   end

   // Capture instruction context on every accept.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         pc_q     <= '0;
         off_q    <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         regw_q   <= 1'b0;
         rd_q     <= '0;
      end else if (accept) begin
         pc_q     <= pc_in;
         off_q    <= alu_result[1:0];
         size_q   <= ld_size;
         signed_q <= ld_signed;
         regw_q   <= reg_write_in;
         rd_q     <= rd_in;
      end
   end

   // Registered commit outputs and retirement counter.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         pc_out        <= '0;
         write_data    <= '0;
         rd_out        <= '0;
         reg_write_out <= 1'b0;
         wb_valid      <= 1'b0;
         retired_count <= '0;
      end else begin
         wb_valid      <= 1'b0;
         reg_write_out <= 1'b0;
         if (wb_valid) retired_count <= retired_count + CNT_W'(1);
         if (acc_commit) begin
            wb_valid      <= 1'b1;
            reg_write_out <= reg_write_in;
            write_data    <= res;
            rd_out        <= rd_in;
            pc_out        <= pc_in;
         end else if (mem_done) begin
            wb_valid      <= 1'b1;
            reg_write_out <= regw_q;
            write_data    <= res;
            rd_out        <= rd_q;
            pc_out        <= pc_q;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage_ext.sv
// tb_wb_stage_ext: directed and randomized checks of wb_stage_ext against a
// cycle-level behavioural model of the write-back stage.
module tb_wb_stage_ext;

   logic        iw_clk = 1'b0;
   logic        iw_rst_n;
   logic        in_valid, in_ready, flush;
   logic [31:0] pc_in, alu_result, read_data;
   logic        mem_ready;
   logic [1:0]  wb_sel, ld_size;
   logic        ld_signed, reg_write_in;
   logic [3:0]  rd_in;
   logic [31:0] pc_out, write_data;
   logic [3:0]  rd_out;
   logic        reg_write_out, wb_valid;
   logic [31:0] retired_count;

   int n_assert = 0;
   int n_fail   = 0;

   // model state
   bit          m_wait;
   bit          m_valid, m_we;
   logic [31:0] m_data, m_pc;
   logic [3:0]  m_rd;
   logic [31:0] m_cnt;
   logic [31:0] h_alu, h_pc;
   logic [1:0]  h_size;
   bit          h_sgn, h_we;
   logic [3:0]  h_rd;

   wb_stage_ext #(.WORD(32), .RADDR(4), .CNT_W(32)) dut (
      .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .pc_in(pc_in), .alu_result(alu_result), .read_data(read_data),
      .mem_ready(mem_ready), .wb_sel(wb_sel), .ld_size(ld_size), .ld_signed(ld_signed),
      .reg_write_in(reg_write_in), .rd_in(rd_in), .pc_out(pc_out), .write_data(write_data),
      .rd_out(rd_out), .reg_write_out(reg_write_out), .wb_valid(wb_valid),
      .retired_count(retired_count)
   );

   always #5 iw_clk = ~iw_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_result(input logic [1:0] sel, input logic [31:0] alu,
         input logic [31:0] pc, input logic [31:0] rdat, input logic [1:0] sz, input bit sgn);
      logic [31:0] v;
      int unsigned off;
      off = alu & 32'd3;
      if (sel == 2'b10) return pc + 32'd4;
      if (sel != 2'b01) return alu;
      if (sz == 2'b10) begin
         v = (rdat >> (8 * off)) & 32'hFF;
         if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         v = (rdat >> (16 * (off / 2))) & 32'hFFFF;
         if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = rdat;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_wait = 0; m_valid = 0; m_we = 0;
      m_data = '0; m_pc = '0; m_rd = '0; m_cnt = '0;
   endtask

   task automatic check_outputs(input string p);
      chk({p, "_wb_valid"}, wb_valid, m_valid);
      chk({p, "_reg_write_out"}, reg_write_out, m_we);
      chk({p, "_write_data"}, write_data, m_data);
      chk({p, "_rd_out"}, rd_out, m_rd);
      chk({p, "_pc_out"}, pc_out, m_pc);
      chk({p, "_retired_count"}, retired_count, m_cnt);
   endtask

   // One clock: predict the effect of the current inputs, clock, compare.
   task automatic tick(input string p);
      bit nv, nwe;
      chk({p, "_in_ready"}, in_ready, !m_wait);
      nv = 0; nwe = 0;
      if (m_valid) m_cnt = m_cnt + 1;
      if (flush) begin
         m_wait = 0;
      end else if (m_wait) begin
         if (mem_ready) begin
            nv = 1; nwe = h_we;
            m_data = model_result(2'b01, h_alu, h_pc, read_data, h_size, h_sgn);
            m_rd = h_rd; m_pc = h_pc; m_wait = 0;
         end
      end else if (in_valid) begin
         if (wb_sel == 2'b01 && !mem_ready) begin
            m_wait = 1;
            h_alu = alu_result; h_pc = pc_in; h_size = ld_size;
            h_sgn = ld_signed; h_we = reg_write_in; h_rd = rd_in;
         end else begin
            nv = 1; nwe = reg_write_in;
            m_data = model_result(wb_sel, alu_result, pc_in, read_data, ld_size, ld_signed);
            m_rd = rd_in; m_pc = pc_in;
         end
      end
      m_valid = nv;
      m_we = nv & nwe;
      @(posedge iw_clk);
      #1;
      check_outputs(p);
   endtask

   task automatic idle();
      in_valid = 0; flush = 0; mem_ready = 0;
   endtask

   task automatic drive(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
         input logic [31:0] rdat, input bit mrdy, input logic [1:0] sz, input bit sgn,
         input bit we, input logic [3:0] rd);
      in_valid = 1; flush = 0; wb_sel = sel; alu_result = alu; pc_in = pc;
      read_data = rdat; mem_ready = mrdy; ld_size = sz; ld_signed = sgn;
      reg_write_in = we; rd_in = rd;
   endtask

   initial begin
      logic [31:0] base;
      iw_rst_n = 0;
      idle();
      pc_in = '0; alu_result = '0; read_data = '0; wb_sel = '0; ld_size = '0;
      ld_signed = 0; reg_write_in = 0; rd_in = '0;
      model_reset();
      #1;
      check_outputs("rst");
      @(posedge iw_clk); #1;
      // inputs presented under reset must not be captured
      drive(2'b00, 32'h5555_5555, 32'h100, '0, 1, 2'b00, 0, 1, 4'd7);
      @(posedge iw_clk); #1;
      check_outputs("rst_hold");
      iw_rst_n = 1;

      // 1: plain ALU op
      drive(2'b00, 32'h0000_1234, 32'h0000_0040, '0, 0, 2'b00, 0, 1, 4'd3);
      tick("t1");
      chk("t1_data_const", write_data, 32'h0000_1234);
      chk("t1_rd_const", rd_out, 4'd3);
      idle();
      tick("t1b");
      chk("t1_count_const", retired_count, 32'd1);

      // 2: sub-word loads
      drive(2'b01, 32'h0000_0002, 32'h44, 32'h1280_3456, 1, 2'b10, 1, 1, 4'd4);
      tick("t2a");
      chk("t2_byte_s", write_data, 32'hFFFF_FF80);
      ld_signed = 0;
      tick("t2b");
      chk("t2_byte_u", write_data, 32'h0000_0080);
      ld_size = 2'b01; ld_signed = 1;
      tick("t2c");
      chk("t2_half_s", write_data, 32'h0000_1280);
      idle();
      tick("t2d");

      // 3: late load data
      drive(2'b01, 32'h0000_0010, 32'h80, 32'hDEAD_BEEF, 0, 2'b00, 0, 1, 4'd9);
      for (int i = 0; i < 4; i++) tick("t3_wait");
      chk("t3_in_ready_const", in_ready, 1'b0);
      mem_ready = 1; read_data = 32'hCAFE_F00D;
      tick("t3_done");
      chk("t3_data_const", write_data, 32'hCAFE_F00D);
      idle();
      tick("t3e");

      // 4: link wrap, then back-to-back ALU ops
      drive(2'b10, 32'h0, 32'hFFFF_FFFC, '0, 0, 2'b00, 0, 1, 4'd14);
      tick("t4_link");
      chk("t4_link_const", write_data, 32'h0000_0000);
      base = retired_count + 1;
      for (int i = 0; i < 4; i++) begin
         drive(2'b00, 32'h100 + i, 32'h200 + 4 * i, '0, 0, 2'b00, 0, 1, 4'(i));
         tick("t4_b2b");
         chk("t4_b2b_valid_const", wb_valid, 1'b1);
      end
      idle();
      tick("t4e");
      chk("t4_count_const", retired_count, base + 4);

      // 5: flush during WAIT_MEM together with mem_ready
      drive(2'b01, 32'h0, 32'h300, '0, 0, 2'b00, 0, 1, 4'd5);
      tick("t5_acc");
      tick("t5_wait");
      base = retired_count;
      flush = 1; mem_ready = 1; read_data = 32'h1111_2222;
      tick("t5_flush");
      chk("t5_valid_const", wb_valid, 1'b0);
      chk("t5_in_ready_const", in_ready, 1'b1);
      chk("t5_count_const", retired_count, base);
      idle();
      tick("t5e");

      // 6: async reset during a commit cycle
      drive(2'b00, 32'hABCD_0001, 32'h400, '0, 0, 2'b00, 0, 1, 4'd6);
      tick("t6_commit");
      idle();
      #2 iw_rst_n = 0;
      #1;
      model_reset();
      check_outputs("t6_async");
      @(posedge iw_clk); #2;
      iw_rst_n = 1;
      drive(2'b00, 32'h0000_0777, 32'h500, '0, 0, 2'b00, 0, 1, 4'd2);
      tick("t6_after");
      idle();
      tick("t6e");
      chk("t6_count_const", retired_count, 32'd1);

      // randomized traffic, upstream holding inputs while the stage stalls
      for (int i = 0; i < 600; i++) begin
         if (!m_wait) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            wb_sel       = 2'($urandom_range(0, 3));
            alu_result   = $urandom;
            pc_in        = $urandom;
            ld_size      = 2'($urandom_range(0, 3));
            ld_signed    = 1'($urandom_range(0, 1));
            reg_write_in = 1'($urandom_range(0, 1));
            rd_in        = 4'($urandom_range(0, 15));
         end
         read_data = $urandom;
         mem_ready = ($urandom_range(0, 2) == 0);
         flush     = ($urandom_range(0, 9) == 0);
         tick("rnd");
      end
      idle();
      tick("rnd_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
